// File: rtl/altsyncram_shadow_model_if.sv
// Port bundle for altsyncram_shadow_model: the port-a write side, the
// port-b read address and every read-result / status output.
//   master: drives writes and read address, observes results (bench side)
//   slave : the shadow model itself
interface altsyncram_shadow_model_if #(
    parameter int WIDTHAD = 8,
    parameter int WIDTH   = 32,
    parameter int BYTE_W  = 8
);
    localparam int LANES = WIDTH / BYTE_W;

    logic               wren_a;
    logic [WIDTHAD-1:0] address_a;
    logic [LANES-1:0]   byteena_a;
    logic [WIDTH-1:0]   valid_a;
    logic [WIDTHAD-1:0] address_b;
    logic [WIDTH-1:0]   valid_b;
    logic               av_b;
    logic               ai_b;
    logic               assign_b;
    logic [WIDTH-1:0]   valid_q_b;
    logic               av_q_b;
    logic               ai_q_b;
    logic               assign_q_b;
    logic               init_busy;

    modport master (
        output wren_a, address_a, byteena_a, valid_a, address_b,
        input  valid_b, av_b, ai_b, assign_b,
        input  valid_q_b, av_q_b, ai_q_b, assign_q_b, init_busy
    );

    modport slave (
        input  wren_a, address_a, byteena_a, valid_a, address_b,
        output valid_b, av_b, ai_b, assign_b,
        output valid_q_b, av_q_b, ai_q_b, assign_q_b, init_busy
    );
endinterface

// File: rtl/altsyncram_shadow_model.sv
// Shadow "valid-bit" model of a simple dual-port RAM: one valid bit per data
// bit. After reset a sweep clears every entry (init_busy high), then port a
// performs byte-enabled writes of valid bits and port b reads them with a
// configurable read-during-write policy and optional output register.
// Ports:
//   clock     - sole clock, rising edge
//   reset     - synchronous, active-high
//   bus       - altsyncram_shadow_model_if.slave (write port a, read port b,
//               valid_b/av_b/ai_b/assign_b, their _q_b delayed copies,
//               init_busy)
module altsyncram_shadow_model #(
    parameter int NUMWORDS = 256,
    parameter int WIDTHAD  = 8,
    parameter int WIDTH    = 32,
    parameter int BYTE_W   = 8,
    parameter int OUTREG   = 0,
    parameter int RDW_MODE = 0
) (
    input  logic                      clock,
    input  logic                      reset,
    altsyncram_shadow_model_if.slave  bus
);
    localparam int LANES  = WIDTH / BYTE_W;
    localparam int MEM_AW = (NUMWORDS > 1) ? $clog2(NUMWORDS) : 1;
    localparam logic [WIDTHAD:0]   NUMWORDS_C = (WIDTHAD+1)'(NUMWORDS);
    localparam logic [WIDTHAD-1:0] LAST_ADDR  = WIDTHAD'(NUMWORDS - 1);

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    // Expand per-lane byte enables into a per-bit mask.
    function automatic logic [WIDTH-1:0] lane_mask(input logic [LANES-1:0] be);
        logic [WIDTH-1:0] m;
        m = '0;
        for (int i = 0; i < LANES; i++) begin
            m[i*BYTE_W +: BYTE_W] = {BYTE_W{be[i]}};
        end
        return m;
    endfunction

    // True when an address maps onto an existing entry.
    function automatic logic in_range(input logic [WIDTHAD-1:0] addr);
        return ({1'b0, addr} < NUMWORDS_C);
    endfunction

    state_t             state_q, state_d;
    logic [WIDTHAD-1:0] cnt_q, cnt_d;
    logic               init_busy_q, init_busy_d;
    logic [WIDTH-1:0]   mem_q [NUMWORDS];

    logic               mem_we_s;
    logic [WIDTHAD-1:0] mem_waddr_s;
    logic [WIDTH-1:0]   mem_wdata_s;
    logic [WIDTH-1:0]   merged_s;
    logic               wr_hit_s;
    logic               rdw_hit_s;

    logic [WIDTH-1:0]   rd_q, rd_d;
    logic [WIDTH-1:0]   out_q, out_d;
    logic [WIDTH-1:0]   valid_b_s;
    logic               av_b_s, ai_b_s, assign_b_s;
    logic [WIDTH-1:0]   valid_qb_q, valid_qb_d;
    logic               av_qb_q, av_qb_d;
    logic               ai_qb_q, ai_qb_d;
    logic               assign_qb_q, assign_qb_d;

    // Port-a write decode: merged word keeps disabled lanes, takes valid_a elsewhere.
    always_comb begin
        merged_s  = (mem_q[bus.address_a[MEM_AW-1:0]] & ~lane_mask(bus.byteena_a))
                  | (bus.valid_a & lane_mask(bus.byteena_a));
        wr_hit_s  = (state_q == ST_RUN) && bus.wren_a && in_range(bus.address_a);
        rdw_hit_s = wr_hit_s && (bus.address_a == bus.address_b);
    end

    // FSM next state, sweep counter and RAM write-port selection.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        mem_we_s    = 1'b0;
        mem_waddr_s = bus.address_a;
        mem_wdata_s = merged_s;
        if (reset) begin
            state_d = ST_CLEAR;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_CLEAR: begin
                    mem_we_s    = 1'b1;
                    mem_waddr_s = cnt_q;
                    mem_wdata_s = '0;
                    if (cnt_q == LAST_ADDR) begin
                        state_d = ST_RUN;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + WIDTHAD'(1);
                    end
                end
                ST_RUN: begin
                    mem_we_s = wr_hit_s;
                end
                default: begin
                    state_d = ST_CLEAR;
                    cnt_d   = '0;
                end
            endcase
        end
        init_busy_d = (state_d == ST_CLEAR);
    end

    // Read pipeline next values: first stage applies range and RDW policy.
    always_comb begin
        rd_d = '0;
        if (reset || (state_q != ST_RUN) || !in_range(bus.address_b)) begin
            rd_d = '0;
        end else if (rdw_hit_s) begin
            case (RDW_MODE)
                0:       rd_d = mem_q[bus.address_b[MEM_AW-1:0]];
                1:       rd_d = merged_s;
                default: rd_d = '0;
            endcase
        end else begin
            rd_d = mem_q[bus.address_b[MEM_AW-1:0]];
        end
        if (reset) begin
            out_d = '0;
        end else begin
            out_d = rd_q;
        end
    end

    // Port-b word selection and combinational uniformity flags.
    always_comb begin
        if (OUTREG != 0) begin
            valid_b_s = out_q;
        end else begin
            valid_b_s = rd_q;
        end
        av_b_s     = &valid_b_s;
        ai_b_s     = ~|valid_b_s;
        assign_b_s = av_b_s | ai_b_s;
    end

    // Delayed copies of the port-b outputs; reset values match an all-zero word.
    always_comb begin
        if (reset) begin
            valid_qb_d  = '0;
            av_qb_d     = 1'b0;
            ai_qb_d     = 1'b1;
            assign_qb_d = 1'b1;
        end else begin
            valid_qb_d  = valid_b_s;
            av_qb_d     = av_b_s;
            ai_qb_d     = ai_b_s;
            assign_qb_d = assign_b_s;
        end
    end

    // Control and pipeline registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_CLEAR;
            cnt_q       <= '0;
            init_busy_q <= 1'b1;
            rd_q        <= '0;
            out_q       <= '0;
            valid_qb_q  <= '0;
            av_qb_q     <= 1'b0;
            ai_qb_q     <= 1'b1;
            assign_qb_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            init_busy_q <= init_busy_d;
            rd_q        <= rd_d;
            out_q       <= out_d;
            valid_qb_q  <= valid_qb_d;
            av_qb_q     <= av_qb_d;
            ai_qb_q     <= ai_qb_d;
            assign_qb_q <= assign_qb_d;
        end
    end

    // Shadow array storage; not reset, the clear sweep initialises it.
    always_ff @(posedge clock) begin
        if (mem_we_s) begin
            mem_q[mem_waddr_s[MEM_AW-1:0]] <= mem_wdata_s;
        end
    end

    assign bus.valid_b    = valid_b_s;
    assign bus.av_b       = av_b_s;
    assign bus.ai_b       = ai_b_s;
    assign bus.assign_b   = assign_b_s;
    assign bus.valid_q_b  = valid_qb_q;
    assign bus.av_q_b     = av_qb_q;
    assign bus.ai_q_b     = ai_qb_q;
    assign bus.assign_q_b = assign_qb_q;
    assign bus.init_busy  = init_busy_q;
endmodule

// File: tb/tb_altsyncram_shadow_model.sv
// Bench for altsyncram_shadow_model: four instances (RDW modes 0/1/2 with no
// output register, plus mode 0 with the output register) share one stimulus
// stream and are compared every cycle against a word-level reference model.
module tb_altsyncram_shadow_model;
    localparam int NW = 16;
    localparam int AW = 5;
    localparam int W  = 32;
    localparam int BW = 8;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    logic          wren   = 1'b0;
    logic [AW-1:0] addr_a = '0;
    logic [3:0]    be     = '0;
    logic [W-1:0]  va     = '0;
    logic [AW-1:0] addr_b = '0;

    altsyncram_shadow_model_if #(.WIDTHAD(AW), .WIDTH(W), .BYTE_W(BW)) if_m0 ();
    altsyncram_shadow_model_if #(.WIDTHAD(AW), .WIDTH(W), .BYTE_W(BW)) if_m1 ();
    altsyncram_shadow_model_if #(.WIDTHAD(AW), .WIDTH(W), .BYTE_W(BW)) if_m2 ();
    altsyncram_shadow_model_if #(.WIDTHAD(AW), .WIDTH(W), .BYTE_W(BW)) if_or ();

    assign if_m0.wren_a = wren;  assign if_m0.address_a = addr_a;
    assign if_m0.byteena_a = be; assign if_m0.valid_a = va; assign if_m0.address_b = addr_b;
    assign if_m1.wren_a = wren;  assign if_m1.address_a = addr_a;
    assign if_m1.byteena_a = be; assign if_m1.valid_a = va; assign if_m1.address_b = addr_b;
    assign if_m2.wren_a = wren;  assign if_m2.address_a = addr_a;
    assign if_m2.byteena_a = be; assign if_m2.valid_a = va; assign if_m2.address_b = addr_b;
    assign if_or.wren_a = wren;  assign if_or.address_a = addr_a;
    assign if_or.byteena_a = be; assign if_or.valid_a = va; assign if_or.address_b = addr_b;

    altsyncram_shadow_model #(.NUMWORDS(NW), .WIDTHAD(AW), .WIDTH(W), .BYTE_W(BW),
        .OUTREG(0), .RDW_MODE(0)) dut_m0 (.clock(clock), .reset(reset), .bus(if_m0.slave));
    altsyncram_shadow_model #(.NUMWORDS(NW), .WIDTHAD(AW), .WIDTH(W), .BYTE_W(BW),
        .OUTREG(0), .RDW_MODE(1)) dut_m1 (.clock(clock), .reset(reset), .bus(if_m1.slave));
    altsyncram_shadow_model #(.NUMWORDS(NW), .WIDTHAD(AW), .WIDTH(W), .BYTE_W(BW),
        .OUTREG(0), .RDW_MODE(2)) dut_m2 (.clock(clock), .reset(reset), .bus(if_m2.slave));
    altsyncram_shadow_model #(.NUMWORDS(NW), .WIDTHAD(AW), .WIDTH(W), .BYTE_W(BW),
        .OUTREG(1), .RDW_MODE(0)) dut_or (.clock(clock), .reset(reset), .bus(if_or.slave));

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model state
    logic [W-1:0] mem [NW];
    int           sweep_left = 0;
    logic [W-1:0] exp_b [4];
    logic [W-1:0] exp_q [4];
    logic [W-1:0] or_stage = '0;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_word(input string tag, input logic [W-1:0] v, input logic av,
                            input logic ai, input logic asg, input logic [W-1:0] e);
        logic eav, eai;
        eav = (e == {W{1'b1}});
        eai = (e == '0);
        chk({tag, ".valid"}, v, e);
        chk({tag, ".av"},     {31'b0, av},  {31'b0, eav});
        chk({tag, ".ai"},     {31'b0, ai},  {31'b0, eai});
        chk({tag, ".assign"}, {31'b0, asg}, {31'b0, eav | eai});
    endtask

    // One clock: predict from the model, advance it, then compare all outputs.
    task automatic step();
        logic [W-1:0] mask, old_w, new_w;
        logic [W-1:0] rd [3];
        bit clr, wr, coll;
        logic busy;
        clr = (sweep_left > 0);
        for (int i = 0; i < 4; i++) mask[i*BW +: BW] = {BW{be[i]}};
        wr    = !reset && !clr && wren && (addr_a < AW'(NW));
        old_w = (addr_b < AW'(NW)) ? mem[addr_b[3:0]] : '0;
        new_w = (mem[addr_a[3:0]] & ~mask) | (va & mask);
        coll  = wr && (addr_a == addr_b);
        if (reset || clr) begin
            rd[0] = '0; rd[1] = '0; rd[2] = '0;
        end else begin
            rd[0] = old_w;
            rd[1] = coll ? new_w : old_w;
            rd[2] = coll ? '0 : old_w;
        end
        for (int i = 0; i < 4; i++) exp_q[i] = reset ? '0 : exp_b[i];
        exp_b[3] = reset ? '0 : or_stage;
        or_stage = rd[0];
        for (int i = 0; i < 3; i++) exp_b[i] = rd[i];
        if (reset) begin
            sweep_left = NW;
            for (int i = 0; i < NW; i++) mem[i] = '0;
        end else if (clr) begin
            sweep_left--;
        end else if (wr) begin
            mem[addr_a[3:0]] = new_w;
        end
        busy = (sweep_left > 0);
        @(posedge clock);
        @(negedge clock);
        chk_word("m0.b", if_m0.valid_b, if_m0.av_b, if_m0.ai_b, if_m0.assign_b, exp_b[0]);
        chk_word("m1.b", if_m1.valid_b, if_m1.av_b, if_m1.ai_b, if_m1.assign_b, exp_b[1]);
        chk_word("m2.b", if_m2.valid_b, if_m2.av_b, if_m2.ai_b, if_m2.assign_b, exp_b[2]);
        chk_word("or.b", if_or.valid_b, if_or.av_b, if_or.ai_b, if_or.assign_b, exp_b[3]);
        chk_word("m0.q", if_m0.valid_q_b, if_m0.av_q_b, if_m0.ai_q_b, if_m0.assign_q_b, exp_q[0]);
        chk_word("m1.q", if_m1.valid_q_b, if_m1.av_q_b, if_m1.ai_q_b, if_m1.assign_q_b, exp_q[1]);
        chk_word("m2.q", if_m2.valid_q_b, if_m2.av_q_b, if_m2.ai_q_b, if_m2.assign_q_b, exp_q[2]);
        chk_word("or.q", if_or.valid_q_b, if_or.av_q_b, if_or.ai_q_b, if_or.assign_q_b, exp_q[3]);
        chk("m0.busy", {31'b0, if_m0.init_busy}, {31'b0, busy});
        chk("or.busy", {31'b0, if_or.init_busy}, {31'b0, busy});
    endtask

    task automatic idle(input logic [AW-1:0] rb);
        wren = 1'b0; be = 4'h0; va = '0; addr_a = '0; addr_b = rb;
    endtask

    task automatic wr_rd(input logic [AW-1:0] wa, input logic [3:0] wbe,
                         input logic [W-1:0] wv, input logic [AW-1:0] rb);
        wren = 1'b1; addr_a = wa; be = wbe; va = wv; addr_b = rb;
    endtask

    initial begin
        int busy_cycles;
        for (int i = 0; i < NW; i++) mem[i] = '0;
        for (int i = 0; i < 4; i++) begin exp_b[i] = '0; exp_q[i] = '0; end

        // Reset pulse, then a write attempted throughout the sweep
        reset = 1'b1; idle(5'd2); step();
        reset = 1'b0;
        busy_cycles = 0;
        for (int i = 0; i < 16; i++) begin
            wr_rd(5'd2, 4'hF, 32'hFFFF_FFFF, 5'd2);
            if (if_m0.init_busy) busy_cycles++;
            step();
        end
        chk("sweep.len", 32'(busy_cycles), 32'd16);
        idle(5'd2); step(); step();
        chk("sweep.write_dropped", if_m0.valid_b, 32'h0);

        // Reset reasserted at sweep cycle 9
        reset = 1'b1; idle(5'd0); step();
        reset = 1'b0;
        for (int i = 0; i < 9; i++) step();
        reset = 1'b1; step();
        reset = 1'b0;
        busy_cycles = 0;
        for (int i = 0; i < 18; i++) begin
            if (if_m0.init_busy) busy_cycles++;
            step();
        end
        chk("midreset.len", 32'(busy_cycles), 32'd16);

        // Full write then read of address 5
        wr_rd(5'd5, 4'hF, 32'hFFFF_FFFF, 5'd0); step();
        idle(5'd5); step();
        chk("rd5.valid_b", if_m0.valid_b, 32'hFFFF_FFFF);
        idle(5'd0); step();
        chk("rd5.valid_q_b", if_m0.valid_q_b, 32'hFFFF_FFFF);

        // Partial lanes on address 3
        wr_rd(5'd3, 4'b0101, 32'hFFFF_FFFF, 5'd0); step();
        idle(5'd3); step();
        chk("lanes.valid_b", if_m0.valid_b, 32'h00FF_00FF);
        chk("lanes.assign_b", {31'b0, if_m0.assign_b}, 32'h0);

        // Read-during-write on address 7 (still clear)
        wr_rd(5'd7, 4'hF, 32'hFFFF_FFFF, 5'd7); step();
        chk("rdw.mode0", if_m0.valid_b, 32'h0);
        chk("rdw.mode1", if_m1.valid_b, 32'hFFFF_FFFF);
        chk("rdw.mode2", if_m2.valid_b, 32'h0);
        idle(5'd7); step();
        chk("rdw.after0", if_m0.valid_b, 32'hFFFF_FFFF);
        chk("rdw.after2", if_m2.valid_b, 32'hFFFF_FFFF);

        // Output-register latency on address 5
        idle(5'd0); step(); step();
        idle(5'd5); step();
        chk("outreg.lat1", if_or.valid_b, 32'h0);
        idle(5'd0); step();
        chk("outreg.lat2", if_or.valid_b, 32'hFFFF_FFFF);

        // Out-of-range write and read; address 4 must not alias address 20
        wr_rd(5'd20, 4'hF, 32'hFFFF_FFFF, 5'd0); step();
        idle(5'd20); step();
        chk("oor.read", if_m0.valid_b, 32'h0);
        idle(5'd4); step();
        chk("oor.alias", if_m0.valid_b, 32'h0);

        // Randomised traffic with biased collisions and one mid-run reset
        for (int n = 0; n < 400; n++) begin
            wren   = ($urandom_range(0, 2) != 0);
            addr_a = ($urandom_range(0, 7) == 0) ? AW'($urandom_range(16, 31))
                                                 : AW'($urandom_range(0, 15));
            be     = 4'($urandom_range(0, 15));
            va     = $urandom;
            addr_b = ($urandom_range(0, 3) == 0) ? addr_a : AW'($urandom_range(0, 31));
            reset  = (n == 200);
            step();
        end
        reset = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
